// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/response master: FSM encoding, SPI mode
// and synchroniser depth.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxCmd,
    StWaitResp,
    StRxResp,
    StCsHold,
    StGap
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam int unsigned SyncDepth = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SCLK generator with MSB-first TX/RX shift registers. One start pulse runs
// DATA_W SCLK cycles; done fires on the clk edge that produces the final falling edge.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_word,
  output logic              done,
  output logic              sclk,
  output logic              mosi
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic SclkIdle = SPI_MODE0[1];

  logic              active_q, active_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              toggle;

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    toggle   = active_q && (div_q == DivW'(CLK_DIV - 1));
    done     = toggle && sclk_q && (bit_q == BitW'(DATA_W - 1));

    if (start) begin
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = SclkIdle;
      tx_d     = tx_word;
      rx_d     = '0;
    end else if (active_q) begin
      div_d = toggle ? '0 : div_q + DivW'(1);
      if (toggle) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[DATA_W-2:0], miso};
        end else begin
          // Zero fill leaves mosi low once the word has gone out.
          tx_d  = {tx_q[DATA_W-2:0], 1'b0};
          bit_d = bit_q + BitW'(1);
          if (done) active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= SclkIdle;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign rx_word = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = tx_q[DATA_W-1];

endmodule

// File: rtl/spi_req_resp_master.sv
// SPI mode-0 master: sends a command, waits for the slave's response_ready (with
// timeout), reads the response under the same cs_n, then hands it to the requester.
module spi_req_resp_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESP_TIMEOUT = 1024,
  parameter int unsigned CS_GAP       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  input  logic              response_ready,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int unsigned GapCycles = CS_GAP * CLK_DIV;
  localparam int unsigned CntMax    = max_u(max_u(RESP_TIMEOUT, GapCycles), CLK_DIV);
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [SyncDepth-1:0] rr_sync_q;

  logic              eng_start;
  logic              eng_done;
  logic [DATA_W-1:0] eng_tx_word;
  logic [DATA_W-1:0] eng_rx_word;

  spi_shift_engine #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shift_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (eng_start),
    .tx_word (eng_tx_word),
    .miso    (miso),
    .rx_word (eng_rx_word),
    .done    (eng_done),
    .sclk    (sclk),
    .mosi    (mosi)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    abort_d       = abort_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;
    eng_start     = 1'b0;
    eng_tx_word   = '0;

    unique case (state_q)
      StIdle: begin
        eng_tx_word = cmd_data;
        if (cmd_valid) begin
          eng_start = 1'b1;
          abort_d   = 1'b0;
          state_d   = StTxCmd;
        end
      end
      StTxCmd: begin
        if (eng_done) begin
          cnt_d   = '0;
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        // A response arriving on the timeout cycle still wins.
        if (rr_sync_q[SyncDepth-1]) begin
          eng_start = 1'b1;
          cnt_d     = '0;
          state_d   = StRxResp;
        end else if (cnt_q == CntW'(RESP_TIMEOUT - 1)) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = StCsHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRxResp: begin
        if (eng_done) begin
          cnt_d   = '0;
          state_d = StCsHold;
        end
      end
      StCsHold: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = abort_q;
          rsp_data_d    = abort_q ? '0 : eng_rx_word;
          cnt_d         = '0;
          state_d       = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (32'(cnt_q) + 32'd1 >= GapCycles) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      rr_sync_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      rr_sync_q     <= {rr_sync_q[SyncDepth-2:0], response_ready};
    end
  end

  // Decoded from state so an asynchronous reset releases the slave at once.
  assign cs_n        = !(state_q inside {StTxCmd, StWaitResp, StRxResp, StCsHold});
  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_spi_req_resp_master.sv
// Directed bench: three master instances (nominal, short timeout, 8-bit/fast clock)
// with a small behavioural slave per instance.
module tb_spi_req_resp_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instances A and B share command data, response_ready and miso.
  logic        cmd_valid_a, cmd_valid_b;
  logic [31:0] cmd_data_ab;
  logic        rr_ab, miso_ab;
  logic        cmd_ready_a, rsp_valid_a, rsp_timeout_a, busy_a, sclk_a, mosi_a, cs_n_a;
  logic [31:0] rsp_data_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_timeout_b, busy_b, sclk_b, mosi_b, cs_n_b;
  logic [31:0] rsp_data_b;

  logic        cmd_valid_c, rr_c, miso_c;
  logic [7:0]  cmd_data_c;
  logic        cmd_ready_c, rsp_valid_c, rsp_timeout_c, busy_c, sclk_c, mosi_c, cs_n_c;
  logic [7:0]  rsp_data_c;

  spi_req_resp_master #(
    .DATA_W(32), .CLK_DIV(4), .RESP_TIMEOUT(1024), .CS_GAP(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data_ab), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rsp_timeout(rsp_timeout_a), .busy(busy_a), .response_ready(rr_ab), .miso(miso_ab),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a)
  );

  spi_req_resp_master #(
    .DATA_W(32), .CLK_DIV(4), .RESP_TIMEOUT(16), .CS_GAP(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data_ab), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rsp_timeout(rsp_timeout_b), .busy(busy_b), .response_ready(rr_ab), .miso(miso_ab),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b)
  );

  spi_req_resp_master #(
    .DATA_W(8), .CLK_DIV(2), .RESP_TIMEOUT(1024), .CS_GAP(2)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c),
    .cmd_data(cmd_data_c), .rsp_valid(rsp_valid_c), .rsp_data(rsp_data_c),
    .rsp_timeout(rsp_timeout_c), .busy(busy_c), .response_ready(rr_c), .miso(miso_c),
    .sclk(sclk_c), .mosi(mosi_c), .cs_n(cs_n_c)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- slave models and monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int          rise_a = 0, rise_b = 0, rise_c = 0, cs_rise_a = 0;
  logic [31:0] mosi_cap_a = '0, resp_word_a = '0;
  logic [7:0]  mosi_cap_c = '0, resp_word_c = '0;
  logic        rx_mosi_a = 1'b0;

  always @(posedge sclk_a or negedge cs_n_a) begin
    if (sclk_a) begin
      if (rise_a < 32) mosi_cap_a = {mosi_cap_a[30:0], mosi_a};
      else rx_mosi_a = rx_mosi_a | mosi_a;
      rise_a++;
    end else begin
      rise_a    = 0;
      rx_mosi_a = 1'b0;
    end
  end

  always @(posedge sclk_b or negedge cs_n_b) begin
    if (sclk_b) rise_b++;
    else rise_b = 0;
  end

  always @(posedge sclk_c or negedge cs_n_c) begin
    if (sclk_c) begin
      if (rise_c < 8) mosi_cap_c = {mosi_cap_c[6:0], mosi_c};
      rise_c++;
    end else begin
      rise_c = 0;
    end
  end

  always @(posedge cs_n_a) cs_rise_a++;

  // Slave presents the next response bit after each falling edge of the RX phase.
  assign miso_ab = (rise_a >= 32 && rise_a < 64) ? resp_word_a[5'(63 - rise_a)] : 1'b0;
  assign miso_c  = (rise_c >= 8 && rise_c < 16) ? resp_word_c[3'(15 - rise_c)] : 1'b0;

  logic [32:0] hist_a[$];
  logic [32:0] hist_b[$];
  logic [8:0]  hist_c[$];
  int          rdy_viol_a = 0, hi_run_a = 0, last_hi_a = 0;
  logic        prev_sclk_c = 1'b0;
  int          run_c = 0, hp_n_c = 0, hp_bad_c = 0;

  always @(negedge clk) begin
    if (rsp_valid_a === 1'b1) hist_a.push_back({rsp_timeout_a, rsp_data_a});
    if (rsp_valid_b === 1'b1) hist_b.push_back({rsp_timeout_b, rsp_data_b});
    if (rsp_valid_c === 1'b1) hist_c.push_back({rsp_timeout_c, rsp_data_c});
    if (cmd_ready_a === busy_a) rdy_viol_a++;
    if (cs_n_a) hi_run_a++;
    else begin
      if (hi_run_a != 0) last_hi_a = hi_run_a;
      hi_run_a = 0;
    end
    // Half-period lengths of C, skipping the low stretch before each phase's first rise.
    if (sclk_c !== prev_sclk_c) begin
      if (prev_sclk_c || (rise_c != 1 && rise_c != 9)) begin
        hp_n_c++;
        if (run_c != 2) hp_bad_c++;
      end
      run_c       = 1;
      prev_sclk_c = sclk_c;
    end else begin
      run_c++;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic ready_of(input int which);
    return (which == 0) ? cmd_ready_a : (which == 1) ? cmd_ready_b : cmd_ready_c;
  endfunction

  function automatic int rsp_cnt(input int which);
    return (which == 0) ? hist_a.size() : (which == 1) ? hist_b.size() : hist_c.size();
  endfunction

  function automatic bit tx_ended(input int which);
    if (which == 0) return rise_a == 32 && !sclk_a;
    if (which == 1) return rise_b == 32 && !sclk_b;
    return rise_c == 8 && !sclk_c;
  endfunction

  task automatic send(input int which, input logic [31:0] d, input bit keep);
    int k = 0;
    @(negedge clk);
    case (which)
      0:       begin cmd_valid_a = 1'b1; cmd_data_ab = d; end
      1:       begin cmd_valid_b = 1'b1; cmd_data_ab = d; end
      default: begin cmd_valid_c = 1'b1; cmd_data_c = d[7:0]; end
    endcase
    while (!ready_of(which) && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) check("send accept bound", 64'd0, 64'd1);
    @(negedge clk);
    case (which)
      0:       cmd_valid_a = keep;
      1:       cmd_valid_b = keep;
      default: cmd_valid_c = keep;
    endcase
  endtask

  task automatic wait_tx_end(input int which, input string tag);
    int k = 0;
    while (!tx_ended(which) && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) check({tag, " tx end bound"}, 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input int which, input int target, input string tag);
    int k = 0;
    while (rsp_cnt(which) < target && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) check({tag, " rsp bound"}, 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int t0, t1, k, c0;
    rst_n = 1'b0;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_valid_c = 1'b0;
    cmd_data_ab = '0; cmd_data_c = '0; rr_ab = 1'b0; rr_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst sclk", 64'(sclk_a), 64'd0);
    check("rst mosi", 64'(mosi_a), 64'd0);
    check("rst cs_n", 64'(cs_n_a), 64'd1);
    check("rst rsp_valid", 64'(rsp_valid_a), 64'd0);
    check("rst rsp_timeout", 64'(rsp_timeout_a), 64'd0);
    check("rst rsp_data", 64'(rsp_data_a), 64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst cmd_ready", 64'(cmd_ready_a), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: nominal exchange, slave ready 50 cycles after TX
    resp_word_a = 32'h1234_5678;
    c0 = cs_rise_a;
    send(0, 32'hA5A5_0F0F, 1'b0);
    wait_tx_end(0, "t1");
    repeat (50) @(negedge clk);
    rr_ab = 1'b1;
    wait_rsp(0, 1, "t1");
    rr_ab = 1'b0;
    check("t1 rsp", 64'(hist_a[0]), {31'd0, 1'b0, 32'h1234_5678});
    check("t1 mosi word", 64'(mosi_cap_a), 64'hA5A5_0F0F);
    check("t1 sclk rises", 64'(rise_a), 64'd64);
    check("t1 cs_n rises", 64'(cs_rise_a - c0), 64'd1);
    check("t1 rx mosi zero", 64'(rx_mosi_a), 64'd0);

    // 2: no response on the short-timeout instance
    send(1, 32'hCAFE_0001, 1'b0);
    wait_tx_end(1, "t2");
    t0 = cyc;
    k = 0;
    while (cs_n_b !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    t1 = cyc;
    check("t2 cs_n release delay", 64'(t1 - t0), 64'd20);
    wait_rsp(1, 1, "t2");
    check("t2 rsp", 64'(hist_b[0]), {31'd0, 1'b1, 32'h0});
    check("t2 sclk rises", 64'(rise_b), 64'd32);

    // 3: response_ready already high before TX ends
    rr_ab = 1'b1;
    resp_word_a = 32'h0BAD_F00D;
    send(0, 32'h5555_AAAA, 1'b0);
    wait_tx_end(0, "t3");
    t0 = cyc;
    k = 0;
    while (rise_a != 33 && k < 5000) begin @(negedge clk); k++; end
    t1 = cyc;
    check("t3 rx start in window", 64'((t1 - t0) >= 5 && (t1 - t0) <= 7), 64'd1);
    wait_rsp(0, 2, "t3");
    check("t3 rsp", 64'(hist_a[1]), {31'd0, 1'b0, 32'h0BAD_F00D});
    check("t3 mosi word", 64'(mosi_cap_a), 64'h5555_AAAA);

    // 4: back-to-back with cmd_valid held high
    resp_word_a = 32'hDEAD_BEEF;
    send(0, 32'h0000_0001, 1'b1);
    send(0, 32'h8000_0000, 1'b0);
    wait_rsp(0, 4, "t4");
    repeat (40) @(negedge clk);
    check("t4 cs_n gap >= 8", 64'(last_hi_a >= 8), 64'd1);
    check("t4 rsp first", 64'(hist_a[2]), {31'd0, 1'b0, 32'hDEAD_BEEF});
    check("t4 rsp second", 64'(hist_a[3]), {31'd0, 1'b0, 32'hDEAD_BEEF});
    check("t4 mosi word", 64'(mosi_cap_a), 64'h8000_0000);
    check("t4 rsp count", 64'(rsp_cnt(0)), 64'd4);
    check("t4 ready/busy exclusive", 64'(rdy_viol_a), 64'd0);

    // 5: reset pulsed in the middle of RX
    resp_word_a = 32'h7777_7777;
    send(0, 32'h1357_9BDF, 1'b0);
    k = 0;
    while (!(rise_a >= 40 && sclk_a) && k < 5000) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    #1;
    check("t5 cs_n on reset", 64'(cs_n_a), 64'd1);
    check("t5 sclk on reset", 64'(sclk_a), 64'd0);
    rr_ab = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 cmd_ready after reset", 64'(cmd_ready_a), 64'd1);
    repeat (300) @(negedge clk);
    check("t5 no rsp for aborted", 64'(rsp_cnt(0)), 64'd4);
    check("t5 cs_n idle", 64'(cs_n_a), 64'd1);

    // 6: 8-bit, CLK_DIV=2 instance
    rr_c = 1'b1;
    resp_word_c = 8'hC3;
    send(2, 32'h0000_003C, 1'b0);
    wait_rsp(2, 1, "t6");
    check("t6 rsp", 64'(hist_c[0]), {55'd0, 1'b0, 8'hC3});
    check("t6 mosi word", 64'(mosi_cap_c), 64'h3C);
    check("t6 sclk rises", 64'(rise_c), 64'd16);
    check("t6 bad half-periods", 64'(hp_bad_c), 64'd0);
    check("t6 half-periods seen", 64'(hp_n_c), 64'd30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
